// File: rtl/rx_decrypt_ctrl.sv
// rx_decrypt_ctrl: hunts for a plaintext sync byte on the serial line, then sequences
// the LFSR keystream and receive enable for a fixed number of frames, emitting each decrypted frame.
module rx_decrypt_ctrl #(
  parameter logic [7:0] SYNC           = 8'hA5,
  parameter logic [7:0] KEY_SEED       = 8'h5A,
  parameter int         PAYLOAD_FRAMES = 4,
  parameter int         HUNT_TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       data_enc,
  output logic       ena,
  output logic       key,
  output logic       frame_valid,
  output logic [3:0] addr_out,
  output logic [3:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       sync_err
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [7:0]  SEED_EFF   = (KEY_SEED == 8'h00) ? 8'h01 : KEY_SEED;
  localparam logic [3:0]  LAST_FRAME = 4'(PAYLOAD_FRAMES - 1);
  localparam logic [15:0] LAST_TCNT  = 16'(HUNT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [6:0]  win_r;
  logic [15:0] tcnt_r;
  logic [7:0]  lfsr_r;
  logic [7:0]  lfsr_next_s;
  logic [6:0]  sr_r;
  logic [2:0]  bitcnt_r;
  logic [3:0]  fcnt_r;

  logic [7:0]  win_shift_s;
  logic [7:0]  byte_s;
  logic        sync_hit_s;
  logic        tmo_s;
  logic        frame_end_s;
  logic        last_frame_s;
  logic        ena_s;
  logic        key_s;
  logic        busy_s;
  logic        done_s;
  logic        frame_valid_s;
  logic        sync_err_s;

  assign win_shift_s  = {win_r, data_enc};
  assign byte_s       = {sr_r, data_enc ^ lfsr_r[7]};
  assign sync_hit_s   = (win_shift_s == SYNC);
  assign tmo_s        = (tcnt_r == LAST_TCNT);
  assign frame_end_s  = (bitcnt_r == 3'd7);
  assign last_frame_s = (fcnt_r == LAST_FRAME);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (abort) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_next_s = start ? ST_HUNT : ST_IDLE;
        ST_HUNT: state_next_s = sync_hit_s ? ST_RECV : (tmo_s ? ST_IDLE : ST_HUNT);
        ST_RECV: state_next_s = (frame_end_s && last_frame_s) ? ST_DONE : ST_RECV;
        ST_DONE: state_next_s = ST_IDLE;
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Keystream generator: reseeded on a sync match, free-running through RECV.
  always_comb begin
    lfsr_next_s = lfsr_r;
    if (state_r == ST_HUNT && sync_hit_s) begin
      lfsr_next_s = SEED_EFF;
    end else if (state_r == ST_RECV) begin
      lfsr_next_s = lfsr_step(lfsr_r);
    end else begin
      lfsr_next_s = lfsr_r;
    end
  end

  // Output decode, looking one cycle ahead so the outputs can be registered.
  always_comb begin
    ena_s         = (state_next_s == ST_RECV);
    key_s         = ena_s ? lfsr_next_s[7] : 1'b0;
    busy_s        = (state_next_s != ST_IDLE);
    done_s        = (state_next_s == ST_DONE);
    frame_valid_s = !abort && (state_r == ST_RECV) && frame_end_s;
    sync_err_s    = !abort && (state_r == ST_HUNT) && !sync_hit_s && tmo_s;
  end

  // Hunt window, counters, deserialiser and frame output holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_r    <= 7'd0;
      tcnt_r   <= 16'd0;
      lfsr_r   <= SEED_EFF;
      sr_r     <= 7'd0;
      bitcnt_r <= 3'd0;
      fcnt_r   <= 4'd0;
      addr_out <= 4'd0;
      data_out <= 4'd0;
    end else begin
      lfsr_r <= lfsr_next_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            win_r  <= 7'd0;
            tcnt_r <= 16'd0;
          end
        end
        ST_HUNT: begin
          win_r  <= win_shift_s[6:0];
          tcnt_r <= tcnt_r + 16'd1;
          if (sync_hit_s) begin
            bitcnt_r <= 3'd0;
            fcnt_r   <= 4'd0;
          end
        end
        ST_RECV: begin
          sr_r     <= byte_s[6:0];
          bitcnt_r <= bitcnt_r + 3'd1;
          // A frame completing on the abort cycle is dropped, keeping the previous one.
          if (frame_end_s && !abort) begin
            addr_out <= byte_s[7:4];
            data_out <= byte_s[3:0];
            fcnt_r   <= fcnt_r + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered control/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ena         <= 1'b0;
      key         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      ena         <= ena_s;
      key         <= key_s;
      busy        <= busy_s;
      done        <= done_s;
      frame_valid <= frame_valid_s;
      sync_err    <= sync_err_s;
    end
  end

endmodule

// File: tb/tb_rx_decrypt_ctrl.sv
// Scoreboard bench for rx_decrypt_ctrl: three instances with different parameters share
// the line; stimulus pushes expected events/keystream bits, a negedge monitor pops and compares.
module tb_rx_decrypt_ctrl;
  localparam int K_FRAME = 0;
  localparam int K_DONE  = 1;
  localparam int K_SERR  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       data_enc;
  logic [2:0] start;
  logic [2:0] en, ky, fv, bz, dn, se;
  logic [3:0] ad [3];
  logic [3:0] da [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ena_run [3];
  logic [7:0] pt [16];

  typedef struct {int dut; int kind; int cyc; int val;} ev_t;
  typedef struct {int dut; int cyc; logic k;} keyev_t;
  ev_t    evq [$];
  keyev_t kq  [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rx_decrypt_ctrl #(.SYNC(8'hA5), .KEY_SEED(8'h5A), .PAYLOAD_FRAMES(4), .HUNT_TIMEOUT(16)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .data_enc(data_enc),
    .ena(en[0]), .key(ky[0]), .frame_valid(fv[0]), .addr_out(ad[0]), .data_out(da[0]),
    .busy(bz[0]), .done(dn[0]), .sync_err(se[0]));

  rx_decrypt_ctrl #(.SYNC(8'hA5), .KEY_SEED(8'h5A), .PAYLOAD_FRAMES(1), .HUNT_TIMEOUT(64)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .data_enc(data_enc),
    .ena(en[1]), .key(ky[1]), .frame_valid(fv[1]), .addr_out(ad[1]), .data_out(da[1]),
    .busy(bz[1]), .done(dn[1]), .sync_err(se[1]));

  rx_decrypt_ctrl #(.SYNC(8'hA5), .KEY_SEED(8'h00), .PAYLOAD_FRAMES(2), .HUNT_TIMEOUT(64)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort), .data_enc(data_enc),
    .ena(en[2]), .key(ky[2]), .frame_valid(fv[2]), .addr_out(ad[2]), .data_out(da[2]),
    .busy(bz[2]), .done(dn[2]), .sync_err(se[2]));

  task automatic push_ev(input int d, input int kind, input int c, input int val);
    ev_t e;
    e.dut = d; e.kind = kind; e.cyc = c; e.val = val;
    evq.push_back(e);
  endtask

  task automatic check_ev(input int d, input int kind, input int val);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("FAIL event dut%0d kind%0d cyc%0d: got unexpected strobe, required none", d, kind, cyc);
    end else begin
      e = evq.pop_front();
      if (e.dut != d || e.kind != kind || e.cyc != cyc || e.val != val) begin
        errors++;
        $display("FAIL event: got dut%0d kind%0d cyc%0d val%0h, required dut%0d kind%0d cyc%0d val%0h",
                 d, kind, cyc, val, e.dut, e.kind, e.cyc, e.val);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Monitor: strobes against the event queue, ena/key against the keystream queue.
  always @(negedge clk) begin
    keyev_t k;
    for (int i = 0; i < 3; i++) begin
      if (fv[i] === 1'b1) check_ev(i, K_FRAME, int'({ad[i], da[i]}));
      if (dn[i] === 1'b1) check_ev(i, K_DONE, ena_run[i]);
      if (se[i] === 1'b1) check_ev(i, K_SERR, 0);
      if (en[i] === 1'b1) begin
        checks++;
        if (kq.size() == 0) begin
          errors++;
          $display("FAIL ena dut%0d cyc%0d: got ena=1, required 0", i, cyc);
        end else begin
          k = kq.pop_front();
          if (k.dut != i || k.cyc != cyc || k.k !== ky[i]) begin
            errors++;
            $display("FAIL key: got dut%0d cyc%0d key=%0b, required dut%0d cyc%0d key=%0b",
                     i, cyc, ky[i], k.dut, k.cyc, k.k);
          end
        end
        ena_run[i]++;
      end else begin
        if (ky[i] === 1'b1) begin
          checks++;
          errors++;
          $display("FAIL key_idle dut%0d cyc%0d: got 1, required 0", i, cyc);
        end
        if (bz[i] !== 1'b1) ena_run[i] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends npre random non-sync bits, the sync byte and pf frames of pt[] encrypted with
  // the reference keystream; optionally aborts/resets at global bit stop_bit or pulses start.
  task automatic run_packet(input int d, input int pf, input logic [7:0] seed, input int npre,
                            input int stop_bit, input bit use_rst, input int start_bit);
    logic [7:0] sy;
    logic [7:0] m;
    logic [7:0] w;
    logic       seq [24];
    logic       kb;
    keyev_t     ke;
    int         s;
    int         b;
    bit         ok;
    sy = 8'hA5;
    s  = 0;
    ok = 1'b0;
    while (!ok) begin
      for (int k = 0; k < npre; k++) seq[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) seq[npre + k] = sy[7 - k];
      w  = 8'h00;
      ok = 1'b1;
      for (int k = 0; k < npre + 7; k++) begin
        w = {w[6:0], seq[k]};
        if (w == sy) ok = 1'b0;
      end
    end
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    for (int k = 0; k < npre + 8; k++) begin
      data_enc = seq[k];
      s = cyc;
      tick();
    end
    m = (seed == 8'h00) ? 8'h01 : seed;
    for (int n = 0; n < pf; n++) begin
      for (int j = 7; j >= 0; j--) begin
        b  = 8 * n + (7 - j);
        kb = m[7];
        data_enc = pt[n][j] ^ kb;
        ke.dut = d; ke.cyc = cyc; ke.k = kb;
        kq.push_back(ke);
        if (b == stop_bit) begin
          if (use_rst) rst_n = 1'b0;
          else abort = 1'b1;
        end
        if (b == start_bit) start[d] = 1'b1;
        m = {m[6:0], ^(m & 8'hB8)};
        tick();
        start[d] = 1'b0;
        if (b == stop_bit) begin
          rst_n    = 1'b1;
          abort    = 1'b0;
          data_enc = 1'b0;
          return;
        end
      end
      push_ev(d, K_FRAME, s + 9 + 8 * n, int'(pt[n]));
    end
    push_ev(d, K_DONE, s + 1 + 8 * pf, 8 * pf);
    data_enc = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int t;
    int d;
    rst_n = 1'b0; abort = 1'b0; data_enc = 1'b0; start = 3'b000;
    for (int i = 0; i < 3; i++) ena_run[i] = 0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs_dut%0d", i),
          int'({fv[i], dn[i], se[i], en[i], ky[i], bz[i], ad[i], da[i]}), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic packet: ciphertext 8'h66 under seed 5A decrypts to 8'h3C.
    pt[0] = 8'h3C;
    run_packet(1, 1, 8'h5A, 0, -1, 1'b0, -1);
    chk("basic_addr", int'(ad[1]), 4'h3);
    chk("basic_data", int'(da[1]), 4'hC);

    // Back-to-back frames.
    pt[0] = 8'h10; pt[1] = 8'h21; pt[2] = 8'h32; pt[3] = 8'h43;
    run_packet(0, 4, 8'h5A, 0, -1, 1'b0, -1);
    chk("b2b_busy_after", int'(bz[0]), 0);

    // Sync timeout with the line held low: HUNT_TIMEOUT=16 hunt cycles, then sync_err.
    data_enc = 1'b0;
    start[0] = 1'b1;
    t = cyc;
    tick();
    start[0] = 1'b0;
    push_ev(0, K_SERR, t + 17, 0);
    repeat (20) tick();
    chk("timeout_busy", int'(bz[0]), 0);

    // Sync offset after random preamble bits.
    for (int n = 0; n < 4; n++) pt[n] = 8'($urandom);
    run_packet(0, 4, 8'h5A, 5, -1, 1'b0, -1);

    // Abort during bit 4 of frame 2.
    for (int n = 0; n < 4; n++) pt[n] = 8'($urandom);
    run_packet(0, 4, 8'h5A, 0, 20, 1'b0, -1);
    chk("abort_ena", int'(en[0]), 0);
    chk("abort_busy", int'(bz[0]), 0);
    chk("abort_hold", int'({ad[0], da[0]}), int'(pt[1]));
    repeat (30) tick();
    chk("abort_hold_later", int'({ad[0], da[0]}), int'(pt[1]));

    // start during RECV is ignored.
    for (int n = 0; n < 4; n++) pt[n] = 8'($urandom);
    run_packet(0, 4, 8'h5A, 2, -1, 1'b0, 10);
    chk("start_recv_busy", int'(bz[0]), 0);

    // Seed 0 behaves as seed 1.
    pt[0] = 8'hC7; pt[1] = 8'h3E;
    run_packet(2, 2, 8'h00, 0, -1, 1'b0, -1);

    // Randomised packets on the 4-frame and zero-seed instances.
    for (int r = 0; r < 6; r++) begin
      d = (r % 2 == 0) ? 0 : 2;
      for (int n = 0; n < 4; n++) pt[n] = 8'($urandom);
      run_packet(d, (d == 0) ? 4 : 2, (d == 0) ? 8'h5A : 8'h00, $urandom_range(0, 5), -1, 1'b0, -1);
    end

    // Reset mid-packet clears every output on the next edge.
    for (int n = 0; n < 4; n++) pt[n] = 8'hFF - 8'(n);
    run_packet(0, 4, 8'h5A, 0, 11, 1'b1, -1);
    chk("midreset_outputs", int'({fv[0], dn[0], se[0], en[0], ky[0], bz[0], ad[0], da[0]}), 0);
    repeat (20) tick();

    // A fresh packet after the reset still works.
    for (int n = 0; n < 4; n++) pt[n] = 8'($urandom);
    run_packet(0, 4, 8'h5A, 3, -1, 1'b0, -1);

    repeat (5) tick();
    chk("events_pending", evq.size(), 0);
    chk("keybits_pending", kq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
